// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer: state encoding, default width and next-state helper.
// COUNTDOWN_AUTORELOAD_EN selects reload-on-expiry instead of stopping in DONE.
package countdown_pkg;

  localparam int DEFAULT_BUS_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // stop outranks expiry; a zero load skips straight to DONE in either build
  function automatic state_t next_state(
    input state_t cur,
    input logic   load_valid,
    input logic   load_zero,
    input logic   ebl,
    input logic   stop,
    input logic   at_one
  );
    next_state = cur;
    case (cur)
      IDLE, DONE: begin
        if (load_valid) next_state = load_zero ? DONE : RUN;
      end
      RUN, HOLD: begin
        if (stop) next_state = IDLE;
        else if (!ebl) next_state = HOLD;
`ifdef COUNTDOWN_AUTORELOAD_EN
        else next_state = RUN;
`else
        else if (at_one) next_state = DONE;
        else next_state = RUN;
`endif
      end
      default: next_state = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/countdown_fsm.sv
// Control FSM for countdown_timer: state register plus registered load_ready/busy/paused decode.
// Honours COUNTDOWN_AUTORELOAD_EN through countdown_pkg::next_state.
module countdown_fsm
  import countdown_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load_valid,
  input  logic load_zero,
  input  logic ebl,
  input  logic stop,
  input  logic at_one,
  output logic load_ready,
  output logic busy,
  output logic paused
);

  state_t state;
  state_t nxt;

  assign nxt = next_state(state, load_valid, load_zero, ebl, stop, at_one);

  // Flags are decoded from the next state so they always match the registered state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      paused     <= 1'b0;
    end else begin
      state      <= nxt;
      load_ready <= (nxt == IDLE) || (nxt == DONE);
      busy       <= (nxt == RUN) || (nxt == HOLD);
      paused     <= (nxt == HOLD);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle tc pulse and sticky done flag.
// Define COUNTDOWN_AUTORELOAD_EN to reload the start value at expiry and keep running.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ebl,
  input  logic                 stop,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [BUS_WIDTH-1:0] load_value,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 busy,
  output logic                 paused,
  output logic                 tc,
  output logic                 done
);

  logic [BUS_WIDTH-1:0] reload;
  logic                 accept;
  logic                 load_zero;
  logic                 at_one;
  logic                 step;
  logic                 expire;

  assign accept    = load_valid & load_ready;
  assign load_zero = (load_value == '0);
  assign at_one    = (out == BUS_WIDTH'(1));
  assign step      = busy & ~stop & ebl;
  assign expire    = step & at_one;

  countdown_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_zero  (load_zero),
    .ebl        (ebl),
    .stop       (stop),
    .at_one     (at_one),
    .load_ready (load_ready),
    .busy       (busy),
    .paused     (paused)
  );

  // Expiry is caught at 1 so the count never wraps below zero
  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= '0;
      reload <= '0;
      tc     <= 1'b0;
      done   <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (accept) begin
        out    <= load_value;
        reload <= load_value;
        done   <= load_zero;
        tc     <= load_zero;
      end else if (busy && stop) begin
        out <= '0;
      end else if (expire) begin
        tc <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
        out <= reload;
`else
        out  <= '0;
        done <= 1'b1;
`endif
      end else if (step) begin
        out <= out - BUS_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: expected tc events are queued at load time and
// matched by a monitor on every tc pulse; directed checks cover count, flags and resets.
module tb_countdown_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ebl = 1'b0;
  logic         stop = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] out;
  logic         busy;
  logic         paused;
  logic         tc;
  logic         done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int           cyc;
    logic [W-1:0] out;
    logic         done;
  } exp_t;

  exp_t expq[$];
  exp_t e;

  countdown_timer #(.BUS_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ebl        (ebl),
    .stop       (stop),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .out        (out),
    .busy       (busy),
    .paused     (paused),
    .tc         (tc),
    .done       (done)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, return at the following falling edge
  task automatic applyStimulus(input logic lv, input logic [W-1:0] val, input logic en, input logic st);
    load_valid = lv;
    load_value = val;
    ebl        = en;
    stop       = st;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expectTc(input int at_cycle, input logic [W-1:0] o, input logic d);
    exp_t x;
    x.cyc  = at_cycle;
    x.out  = o;
    x.done = d;
    expq.push_back(x);
  endtask

  task automatic checkIdleReset(input string tag);
    checkOutput({tag, "_out"}, 32'(out), 0);
    checkOutput({tag, "_ready"}, 32'(load_ready), 1);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_paused"}, 32'(paused), 0);
    checkOutput({tag, "_tc"}, 32'(tc), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
  endtask

  // Monitor: every tc pulse must match the oldest queued expectation
  initial forever begin
    @(negedge clk);
    if (tc === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_tc actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        e = expq.pop_front();
        checkOutput("tc_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("tc_out", 32'(out), 32'(e.out));
        checkOutput("tc_done", 32'(done), 32'(e.done));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleReset("reset");
    rst = 1'b0;

    // Zero load: straight to DONE, tc on the next cycle, busy never set
    expectTc(cyc + 1, 0, 1);
    applyStimulus(1, 0, 1, 0);
    checkOutput("zero_busy", 32'(busy), 0);
    checkOutput("zero_done", 32'(done), 1);
    checkOutput("zero_ready", 32'(load_ready), 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("zero_busy2", 32'(busy), 0);
    checkOutput("zero_tc_gone", 32'(tc), 0);

`ifdef COUNTDOWN_AUTORELOAD_EN
    // Autoreload: 3,2,1 then back to 3 with a tc each period, done stays low
    expectTc(cyc + 1 + 3, 3, 0);
    expectTc(cyc + 1 + 6, 3, 0);
    expectTc(cyc + 1 + 9, 3, 0);
    applyStimulus(1, 3, 1, 0);
    checkOutput("ar_done_clr", 32'(done), 0);
    checkOutput("ar_load", 32'(out), 3);
    load_valid = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput("ar_out", 32'(out), 32'(3 - (i % 3)));
      checkOutput("ar_done", 32'(done), 0);
      checkOutput("ar_ready", 32'(load_ready), 0);
    end
    applyStimulus(0, 0, 1, 1);
    checkOutput("ar_stop_out", 32'(out), 0);
    checkOutput("ar_stop_busy", 32'(busy), 0);
    checkOutput("ar_stop_ready", 32'(load_ready), 1);
    applyStimulus(0, 0, 0, 0);
`else
    // V=5 with ebl high: 5,4,3,2,1 then 0 with tc five edges after the load
    expectTc(cyc + 1 + 5, 0, 1);
    applyStimulus(1, 5, 1, 0);
    checkOutput("v5_load", 32'(out), 5);
    checkOutput("v5_ready", 32'(load_ready), 0);
    checkOutput("v5_busy", 32'(busy), 1);
    checkOutput("v5_done_clr", 32'(done), 0);
    for (int v = 4; v >= 0; v--) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput("v5_out", 32'(out), 32'(v));
    end
    checkOutput("v5_done", 32'(done), 1);
    checkOutput("v5_ready_back", 32'(load_ready), 1);
    checkOutput("v5_busy_off", 32'(busy), 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("v5_tc_one_cycle", 32'(tc), 0);
    checkOutput("v5_hold_zero", 32'(out), 0);

    // V=4 with three paused cycles: tc seven edges after the load
    expectTc(cyc + 1 + 7, 0, 1);
    applyStimulus(1, 4, 0, 0);
    checkOutput("v4_done_clr", 32'(done), 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("v4_out_a", 32'(out), 3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("v4_paused", 32'(paused), 1);
      checkOutput("v4_held", 32'(out), 3);
    end
    for (int v = 2; v >= 0; v--) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput("v4_out_b", 32'(out), 32'(v));
      checkOutput("v4_paused_off", 32'(paused), 0);
    end
    applyStimulus(0, 0, 1, 0);
    checkOutput("v4_no_wrap", 32'(out), 0);

    // V=6, stop at 3: back to IDLE without tc
    applyStimulus(1, 6, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
    checkOutput("stop_pre", 32'(out), 3);
    applyStimulus(0, 0, 1, 1);
    checkIdleReset("stop");

    // Second run reset at 2: everything back to reset values
    applyStimulus(1, 5, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
    checkOutput("rst_pre", 32'(out), 2);
    rst = 1'b1;
    applyStimulus(0, 0, 1, 0);
    checkIdleReset("rst_mid");
    rst = 1'b0;

    // Load attempts while running are ignored
    expectTc(cyc + 1 + 7, 0, 1);
    applyStimulus(1, 7, 1, 0);
    applyStimulus(1, 2, 1, 0);
    checkOutput("ign_out_a", 32'(out), 6);
    applyStimulus(1, 9, 1, 0);
    checkOutput("ign_out_b", 32'(out), 5);
    for (int v = 4; v >= 0; v--) applyStimulus(0, 0, 1, 0);
    checkOutput("ign_done", 32'(done), 1);

    // New load from DONE clears done on the acceptance edge
    expectTc(cyc + 1 + 3, 0, 1);
    applyStimulus(1, 3, 1, 0);
    checkOutput("reload_done_clr", 32'(done), 0);
    checkOutput("reload_out", 32'(out), 3);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0);
    checkOutput("reload_done", 32'(done), 1);
`endif

    checkOutput("pending_tc", 32'(expq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter that accepts a start value over a valid/ready load handshake and decrements toward zero while enabled. It flags expiry with a one-cycle terminal-count pulse and a sticky done level. It is the companion to the team's free-running up counter: that block measures elapsed cycles, and this one counts a programmed interval down to expiry. Typical use is timeouts and programmable delays in control paths.

## Interface
- BUS_WIDTH, 4, width of count value and load value
- clk  in  1  clock, all activity on rising edge
- rst  in  1  reset, synchronous, active-high
- ebl  in  1  count enable; decrement permitted only when 1
- stop  in  1  abort: return to IDLE without expiry
- load_valid  in  1  load request
- load_ready  out  1  block can accept a load
- load_value  in  BUS_WIDTH  start value
- out  out  BUS_WIDTH  current count
- busy  out  1  1 in RUN or HOLD
- paused  out  1  1 in HOLD
- tc  out  1  terminal-count pulse, exactly one cycle
- done  out  1  sticky expiry flag, cleared by next load

## Operation
- States are IDLE, RUN, HOLD, DONE. Reset values: state IDLE, out=0, reload register=0, load_ready=1, busy=0, paused=0, tc=0, done=0.
- load_ready=1 in IDLE and DONE, 0 in RUN and HOLD. A load during RUN/HOLD is ignored and not queued.
- Load accepted (load_valid & load_ready at an edge):
  - out<=load_value, reload<=load_value, done<=0.
  - load_value!=0 -> RUN.
  - load_value==0 -> DONE with tc=1 and done=1 on the next cycle, and no reload in either configuration.
- RUN/HOLD transitions:
  - ebl=1 -> out<=out-1, next state RUN.
  - ebl=0 -> out held, next state HOLD.
  - HOLD->RUN on the edge where ebl=1, and that edge also decrements.
- Expiry: ebl=1 with out==1 -> out<=0, tc<=1 for one cycle, done<=1, state DONE.
- DONE: out stays 0 and done stays 1 until a load or rst. ebl is ignored.
- stop=1 in RUN/HOLD -> IDLE, out<=0, no tc, done unchanged. stop in IDLE/DONE has no effect.
- Priority, highest first: rst > stop > expiry/decrement.
- Arithmetic is unsigned BUS_WIDTH. out never wraps below 0, because expiry is detected at 1.
- Max value 2^BUS_WIDTH-1 gives that many enabled cycles.

## Timing
- Load accepted at edge N: out=V valid after edge N, busy=1 after edge N.
- With ebl held high, tc=1 during the cycle after edge N+V and out=0 from that point.
- Each cycle with ebl=0 in RUN/HOLD delays expiry by exactly one cycle.
- tc and done are registered, with no combinational path from inputs.
- load_ready is a function of state only, with no dependence on load_valid.

## Configuration
- COUNTDOWN_AUTORELOAD_EN defined: at expiry, out<=reload value and tc pulses, state stays RUN, and done is not set. The period is V enabled cycles and runs indefinitely until stop or rst. load_ready stays 0 while running.
- Undefined: expiry always goes to DONE as described above.
- A load of 0 goes to DONE in both configurations.

## Structure
- Package countdown_pkg holds the state enum (IDLE, RUN, HOLD, DONE) and the default BUS_WIDTH constant.
- One sub-module, countdown_fsm: state register, next-state logic, load_ready/busy/paused decode.
- Count/reload datapath, tc and done live in countdown_timer.

## Test plan
- Reset, then load V=5 with ebl=1 -> load_ready drops, out 5,4,3,2,1,0, tc high one cycle at 5 cycles after the load edge, done=1, load_ready=1.
- Load V=4, ebl low for 3 cycles mid-count -> paused=1 for those cycles, tc 7 cycles after the load edge, out never below 0.
- Load V=0 -> tc one cycle on the next cycle, done=1, busy never asserted.
- Load V=6, assert stop at out=3 -> IDLE, out=0, no tc. Then rst during a second run at out=2 -> all outputs return to reset values.
- load_valid held during RUN with a different value -> ignored, count unchanged. In DONE, a new load clears done on the acceptance edge.
- With COUNTDOWN_AUTORELOAD_EN, load V=3, ebl=1 -> tc every 3 cycles, out 3,2,1,3,2,1…, done stays 0, and stop returns to IDLE.
